packet_buffer_read_arbiter: RTL and testbench
=============================================

# packet_buffer_read_arbiter

Shares the single read port of the packet buffer RAM driver between two requesters: port 0 (UART dump) and port 1 (Ethernet transmit/packet synthesis). Each requester keeps the level-held request / one-cycle ready handshake it would use against the RAM driver directly. The arbiter serialises their reads, optionally locks the port for a burst, and aborts reads the RAM never answers. It sits between the requesters and the packet buffer RAM driver, in the 50 MHz `clk` domain.

## Interface
- `RAM_SIZE`, default `PACKET_BUFFER_SIZE`: depth of the RAM in bytes; address width `AW = clog2(RAM_SIZE)`.
- `DATA_WIDTH`, default `BYTE_LEN` (8): read data width.
- `TIMEOUT_CYCLES`, default 255: maximum number of WAIT cycles before a read is aborted; range 1..255.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1 each  read request; held high until the matching `ready` pulse.
- `addr0`, `addr1`  in  AW each  read address; must be stable while the matching `req` is high.
- `lock0`, `lock1`  in  1 each  burst lock; keeps the grant on that port across consecutive reads.
- `ready0`, `ready1`  out  1 each  one-cycle completion pulse.
- `data0`, `data1`  out  DATA_WIDTH each  read data; valid with `ready` and held until the next completion on that port.
- `err0`, `err1`  out  1 each  one-cycle pulse, coincident with `ready`, when the read timed out.
- `ram_read_req`  out  1  read request to the RAM driver, level.
- `ram_read_addr`  out  AW  read address to the RAM driver.
- `ram_read_ready`  in  1  RAM driver completion strobe.
- `ram_read_out`  in  DATA_WIDTH  RAM driver read data.
- `owner`  out  1  port of the current or most recent grant.
- `busy`  out  1  high in every state except IDLE.

## Operation
- All outputs and internal state are registered. Reset values: `ready*`, `err*`, `ram_read_req`, `busy`, `owner` = 0; `data*` and `ram_read_addr` = 0; state = IDLE; round-robin pointer = 0; lock flag = 0.
- **IDLE**
  - If the lock flag is set and `req[owner]` is high: re-grant `owner`.
  - Otherwise, if only one `req` is high: grant it.
  - Otherwise, if both are high: choose by arbitration policy (see Configuration).
  - On grant: latch `owner` and `ram_read_addr <= addrN`, set `ram_read_req <= 1`, clear the timeout counter, go to WAIT.
- **WAIT**
  - `ram_read_req` stays at 1; the counter increments each cycle.
  - If `ram_read_ready` is high:
    - `dataN <= ram_read_out`, `readyN <= 1`, `ram_read_req <= 0`, go to RELEASE.
    - Latch the lock flag `<= lockN`.
    - Toggle the pointer only if `lockN` is 0.
  - Else, if the counter reaches `TIMEOUT_CYCLES`:
    - `dataN <= 0`, `readyN <= 1`, `errN <= 1`, `ram_read_req <= 0`, lock flag `<= 0`, pointer toggles, go to RELEASE.
- **RELEASE**
  - Exactly one cycle: `ready*` and `err*` return to 0, go to IDLE.
  - Requests are not sampled in this state. This absorbs the requester's one-cycle-late drop of `req`, so no double issue occurs.
- **Lock release:** if the lock flag is set but `req[owner]` is low in IDLE, the flag clears and normal arbitration applies in that same cycle.
- **Stale strobe:** `ram_read_ready` seen in IDLE or RELEASE (a late answer after a timeout) is ignored.
- **Reset mid-read:** asserting `reset_n` low mid-read immediately drops `ram_read_req`, drops all pulses, and returns to IDLE. A pending RAM answer is then ignored as a stale strobe.
- A `req` deasserted while that port is granted is protocol misuse; the read still completes and `ready` still pulses.

## Timing
- Request in cycle 0 (IDLE) → `ram_read_req` high in cycle 1.
- `ram_read_ready` in cycle k → `readyN`/`dataN` in cycle k+1; `ram_read_req` is low from cycle k+1.
- IDLE re-entered in cycle k+2; the next grant is at the earliest issued in cycle k+3.
- Minimum issue spacing = RAM latency + 3 cycles.
- Timeout: `ram_read_req` stays high for exactly `TIMEOUT_CYCLES` cycles; `errN` follows in the next cycle.
- Requester `req` to `ready` minimum latency = RAM latency + 2 cycles.

## Configuration
- `PBUF_ARB_ROUND_ROBIN_EN` defined:
  - Simultaneous requests go to the port indicated by the pointer.
  - The pointer flips after every unlocked completion or timeout.
- `PBUF_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: port 1 (Ethernet transmit) always wins simultaneous requests.
  - The pointer is not implemented.
- The lock behaviour is identical in both builds.

## Test plan
- Single read: `req0`, `addr0=0x010`, RAM answers 2 cycles after `ram_read_req` with 0xA5 → `ram_read_addr=0x010`, `ready0` pulses once with `data0=0xA5`, no second `ram_read_req`.
- Contention: `req0` and `req1` both high at cycle 0, each held through 4 reads:
  - Round-robin build → grants alternate 0,1,0,1.
  - Fixed-priority build → 1,1,1,1 before any port 0 grant.
- Lock burst: `lock1=1` with `req1` reasserted immediately for 3 reads while `req0` is high → three consecutive port 1 grants; port 0 is granted only after `lock1` drops.
- Timeout: `TIMEOUT_CYCLES=8`, RAM never answers → `ram_read_req` high for 8 cycles, then `ready0` and `err0` pulse with `data0=0x00`; a late `ram_read_ready` 3 cycles afterwards produces no `ready` pulse.
- Reset mid-WAIT: `reset_n` driven low with `ram_read_req` high → all outputs reach their reset values without a clock edge; after release, a fresh `req1` completes normally.

Source files
------------

// File: rtl/packet_buffer_read_arbiter.sv
// Two-port read arbiter in front of the packet buffer RAM driver: serialises reads, supports burst lock and read timeout.
// Build option: define PBUF_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: port 1 fixed priority).
module packet_buffer_read_arbiter #(
  parameter int RAM_SIZE       = 2048,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int AW            = $clog2(RAM_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [AW-1:0]         addr0,
  input  logic [AW-1:0]         addr1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  ready0,
  output logic                  ready1,
  output logic [DATA_WIDTH-1:0] data0,
  output logic [DATA_WIDTH-1:0] data1,
  output logic                  err0,
  output logic                  err1,
  output logic                  ram_read_req,
  output logic [AW-1:0]         ram_read_addr,
  input  logic                  ram_read_ready,
  input  logic [DATA_WIDTH-1:0] ram_read_out,
  output logic                  owner,
  output logic                  busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RELEASE} state_t;

  // Counter value seen in the last WAIT cycle before the read is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  lock_q, lock_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  owner_d, ram_read_req_d, busy_d;
  logic [AW-1:0]         ram_read_addr_d;
  logic                  ready0_d, ready1_d, err0_d, err1_d;
  logic [DATA_WIDTH-1:0] data0_d, data1_d;
  logic                  grant, grant_port, both_pick;
  logic [1:0]            req_vec, lock_vec;

`ifdef PBUF_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  assign both_pick = ptr_q;
`else
  assign both_pick = 1'b1;
`endif

  assign req_vec  = {req1, req0};
  assign lock_vec = {lock1, lock0};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    lock_d          = lock_q;
    cnt_d           = cnt_q;
    owner_d         = owner;
    ram_read_req_d  = ram_read_req;
    ram_read_addr_d = ram_read_addr;
    ready0_d        = 1'b0;
    ready1_d        = 1'b0;
    err0_d          = 1'b0;
    err1_d          = 1'b0;
    data0_d         = data0;
    data1_d         = data1;
    grant           = 1'b0;
    grant_port      = 1'b0;
`ifdef PBUF_ARB_ROUND_ROBIN_EN
    ptr_d           = ptr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (lock_q && req_vec[owner]) begin
          grant      = 1'b1;
          grant_port = owner;
        end else begin
          // A lock whose owner has let go is dropped and arbitration proceeds this cycle.
          lock_d = 1'b0;
          if (req0 && req1) begin
            grant      = 1'b1;
            grant_port = both_pick;
          end else if (req0 || req1) begin
            grant      = 1'b1;
            grant_port = req1;
          end
        end
        if (grant) begin
          owner_d         = grant_port;
          ram_read_addr_d = grant_port ? addr1 : addr0;
          ram_read_req_d  = 1'b1;
          cnt_d           = '0;
          state_d         = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (ram_read_ready) begin
          if (owner) begin
            data1_d  = ram_read_out;
            ready1_d = 1'b1;
          end else begin
            data0_d  = ram_read_out;
            ready0_d = 1'b1;
          end
          ram_read_req_d = 1'b0;
          lock_d         = lock_vec[owner];
`ifdef PBUF_ARB_ROUND_ROBIN_EN
          if (!lock_vec[owner]) ptr_d = ~ptr_q;
`endif
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          if (owner) begin
            data1_d  = '0;
            ready1_d = 1'b1;
            err1_d   = 1'b1;
          end else begin
            data0_d  = '0;
            ready0_d = 1'b1;
            err0_d   = 1'b1;
          end
          ram_read_req_d = 1'b0;
          lock_d         = 1'b0;
`ifdef PBUF_ARB_ROUND_ROBIN_EN
          ptr_d = ~ptr_q;
`endif
          state_d = ST_RELEASE;
        end
      end

      // Requests are ignored here so the requester's late drop of req cannot re-issue.
      ST_RELEASE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      lock_q        <= 1'b0;
      cnt_q         <= '0;
      owner         <= 1'b0;
      ram_read_req  <= 1'b0;
      ram_read_addr <= '0;
      ready0        <= 1'b0;
      ready1        <= 1'b0;
      err0          <= 1'b0;
      err1          <= 1'b0;
      data0         <= '0;
      data1         <= '0;
      busy          <= 1'b0;
`ifdef PBUF_ARB_ROUND_ROBIN_EN
      ptr_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      lock_q        <= lock_d;
      cnt_q         <= cnt_d;
      owner         <= owner_d;
      ram_read_req  <= ram_read_req_d;
      ram_read_addr <= ram_read_addr_d;
      ready0        <= ready0_d;
      ready1        <= ready1_d;
      err0          <= err0_d;
      err1          <= err1_d;
      data0         <= data0_d;
      data1         <= data1_d;
      busy          <= busy_d;
`ifdef PBUF_ARB_ROUND_ROBIN_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// Scoreboard bench for packet_buffer_read_arbiter: directed reads, contention, lock burst, timeout, reset mid-read.
// Expected grant order follows PBUF_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_packet_buffer_read_arbiter;

  localparam int AW      = 11;
  localparam int DW      = 8;
  localparam int RAM_LAT = 2;

  typedef struct {
    bit            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          ready0, ready1, err0, err1;
  logic [DW-1:0] data0, data1;
  logic          ram_read_req;
  logic [AW-1:0] ram_read_addr;
  logic          ram_read_ready;
  logic [DW-1:0] ram_read_out;
  logic          owner, busy;

  logic          model_rdy = 1'b0, inj_rdy = 1'b0;
  logic [DW-1:0] model_out = '0;
  bit            ram_mute = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rdy_count = 0;
  exp_t iss_q[$];
  exp_t rsp_q[$];

  assign ram_read_ready = model_rdy | inj_rdy;
  assign ram_read_out   = inj_rdy ? 8'hEE : model_out;

  always #5 clk = ~clk;

  packet_buffer_read_arbiter #(
    .RAM_SIZE(2048), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .lock0(lock0), .lock1(lock1),
    .ready0(ready0), .ready1(ready1), .data0(data0), .data1(data1),
    .err0(err0), .err1(err1),
    .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr),
    .ram_read_ready(ram_read_ready), .ram_read_out(ram_read_out),
    .owner(owner), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit port, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input bit err);
    exp_t e;
    e.port = port; e.addr = addr; e.data = data; e.err = err;
    return e;
  endfunction

  // RAM driver model: answers RAM_LAT cycles after ram_read_req with addr[7:0] ^ 0xB5.
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && ram_read_req && !ram_mute) begin
        a = ram_read_addr;
        repeat (RAM_LAT) @(posedge clk);
        #1;
        model_rdy = 1'b1;
        model_out = a[7:0] ^ 8'hB5;
        @(posedge clk);
        #1;
        model_rdy = 1'b0;
      end
    end
  end

  // Monitor: checks every new RAM issue and every ready pulse against the queues.
  initial begin
    bit   prev_req = 1'b0;
    exp_t e;
    bit   p;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        prev_req = 1'b0;
      end else begin
        if (ram_read_req && !prev_req) begin
          if (iss_q.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
          else begin
            e = iss_q.pop_front();
            check("issue_owner", 32'(owner), 32'(e.port));
            check("issue_addr", 32'(ram_read_addr), 32'(e.addr));
          end
        end
        prev_req = ram_read_req;
        if ((err0 && !ready0) || (err1 && !ready1)) check("err_without_ready", 32'd1, 32'd0);
        if (ready0 || ready1) begin
          rdy_count++;
          if (ready0 && ready1) check("dual_ready", 32'd1, 32'd0);
          p = ready1;
          if (rsp_q.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
          else begin
            e = rsp_q.pop_front();
            check("rsp_port", 32'(p), 32'(e.port));
            check("rsp_data", 32'(p ? data1 : data0), 32'(e.data));
            check("rsp_err", 32'(p ? err1 : err0), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic wait_ready(input bit port, output bit got);
    got = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (port ? ready1 : ready0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check(port ? "ready_wait_p1" : "ready_wait_p0", 32'd0, 32'd1);
  endtask

  task automatic wait_issue();
    bit seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (ram_read_req) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("issue_wait", 32'd0, 32'd1);
  endtask

  // Requester: holds req for n reads, drops lock after lock_reads completions, drops req one cycle late.
  task automatic run_reads(input bit port, input logic [AW-1:0] a, input int n, input int lock_reads);
    bit got;
    if (port) begin addr1 = a; lock1 = (lock_reads > 0); req1 = 1'b1; end
    else      begin addr0 = a; lock0 = (lock_reads > 0); req0 = 1'b1; end
    for (int i = 1; i <= n; i++) begin
      wait_ready(port, got);
      if (!got) break;
      if (i == lock_reads) begin
        if (port) lock1 = 1'b0; else lock0 = 1'b0;
      end
    end
    if (port) begin req1 = 1'b0; lock1 = 1'b0; end
    else      begin req0 = 1'b0; lock0 = 1'b0; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int saved;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_read_req", 32'(ram_read_req), 32'd0);
    check("rst_ready", 32'({ready1, ready0, err1, err0}), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Contention: both ports request in the same cycle, 4 reads each.
`ifdef PBUF_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      iss_q.push_back(mk(0, 11'h030, 8'h85, 0)); rsp_q.push_back(mk(0, 11'h030, 8'h85, 0));
      iss_q.push_back(mk(1, 11'h041, 8'hF4, 0)); rsp_q.push_back(mk(1, 11'h041, 8'hF4, 0));
    end
`else
    for (int i = 0; i < 4; i++) begin
      iss_q.push_back(mk(1, 11'h041, 8'hF4, 0)); rsp_q.push_back(mk(1, 11'h041, 8'hF4, 0));
    end
    for (int i = 0; i < 4; i++) begin
      iss_q.push_back(mk(0, 11'h030, 8'h85, 0)); rsp_q.push_back(mk(0, 11'h030, 8'h85, 0));
    end
`endif
    fork
      run_reads(1'b0, 11'h030, 4, 0);
      run_reads(1'b1, 11'h041, 4, 0);
    join
    repeat (4) @(negedge clk);

    // Single read on port 0.
    iss_q.push_back(mk(0, 11'h010, 8'hA5, 0));
    rsp_q.push_back(mk(0, 11'h010, 8'hA5, 0));
    run_reads(1'b0, 11'h010, 1, 0);
    repeat (8) @(negedge clk);
    check("single_idle_after", 32'(busy), 32'd0);

    // Lock burst: port 1 locked for three reads while port 0 waits.
    for (int i = 0; i < 3; i++) begin
      iss_q.push_back(mk(1, 11'h07F, 8'hCA, 0)); rsp_q.push_back(mk(1, 11'h07F, 8'hCA, 0));
    end
    iss_q.push_back(mk(0, 11'h100, 8'hB5, 0));
    rsp_q.push_back(mk(0, 11'h100, 8'hB5, 0));
    fork
      run_reads(1'b1, 11'h07F, 3, 2);
      begin
        wait_issue();
        run_reads(1'b0, 11'h100, 1, 0);
      end
    join
    repeat (4) @(negedge clk);

    // Timeout: RAM silent, ram_read_req must stay high for exactly 8 cycles.
    ram_mute = 1'b1;
    iss_q.push_back(mk(0, 11'h010, 8'h00, 0));
    rsp_q.push_back(mk(0, 11'h010, 8'h00, 1));
    addr0 = 11'h010;
    req0  = 1'b1;
    wait_issue();
    hi = 0;
    while (ram_read_req && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("timeout_req_cycles", 32'(hi), 32'd8);
    check("timeout_ready0", 32'({ready0, err0}), 32'h3);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 saved = rdy_count;
    @(posedge clk);
    #1 inj_rdy = 1'b1;
    @(posedge clk);
    #1 inj_rdy = 1'b0;
    repeat (6) @(negedge clk);
    check("late_strobe_no_ready", 32'(rdy_count), 32'(saved));
    check("late_strobe_data0", 32'(data0), 32'd0);
    check("late_strobe_idle", 32'({busy, ram_read_req}), 32'd0);

    // Reset while a port 1 read is waiting on the RAM.
    iss_q.push_back(mk(1, 11'h0C3, 8'h00, 0));
    addr1 = 11'h0C3;
    req1  = 1'b1;
    wait_issue();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ram_read_req", 32'(ram_read_req), 32'd0);
    check("midrst_busy_owner", 32'({busy, owner}), 32'd0);
    check("midrst_ram_read_addr", 32'(ram_read_addr), 32'd0);
    check("midrst_data", 32'({data1, data0}), 32'd0);
    check("midrst_pulses", 32'({ready1, ready0, err1, err0}), 32'd0);
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    ram_mute = 1'b0;
    repeat (2) @(negedge clk);
    iss_q.push_back(mk(1, 11'h0C3, 8'h76, 0));
    rsp_q.push_back(mk(1, 11'h0C3, 8'h76, 0));
    run_reads(1'b1, 11'h0C3, 1, 0);

    repeat (10) @(negedge clk);
    check("issue_queue_drained", 32'(iss_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
